// File: rtl/serial_nibble_receiver.sv
// serial_nibble_receiver
//   Recovers 7-bit async frames (start 0, 4 data bits LSB first, even parity,
//   stop 1) from a serial line and presents the nibble and parity bit in
//   parallel with a one-cycle valid strobe. Parity and framing errors are
//   flagged alongside so the frame can be qualified immediately.
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-high reset
//   rxd    in   serial line, idles high, asynchronous to clk
//   data   out  [3:0] received nibble, data[0] is the first bit on the line
//   par    out  received parity bit
//   valid  out  one-cycle strobe, data/par/perr/ferr fresh in that cycle
//   perr   out  parity error (odd number of ones across data and par)
//   ferr   out  framing error (stop bit sampled low)
//   busy   out  receiver not idle (registered, follows the state by one cycle)
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | line idle, waiting for a falling edge on the synchronized line
// START   | half-bit wait, then confirm start bit (high = glitch, back to IDLE)
// DATA    | sample four data bits at bit centres, LSB first
// PARITY  | sample the parity bit
// STOP    | sample the stop bit and publish the frame
// BREAK   | stop bit was low; wait for the line to return high

module serial_nibble_receiver #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [3:0] data,
  output logic       par,
  output logic       valid,
  output logic       perr,
  output logic       ferr,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_TC = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state;
  logic [1:0]    sync;
  logic          rxd_s;
  logic [CW-1:0] cnt;
  logic [1:0]    bitidx;
  logic [3:0]    shreg;
  logic          par_s;

  assign rxd_s = sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync   <= 2'b11;
      state  <= S_IDLE;
      cnt    <= '0;
      bitidx <= 2'd0;
      shreg  <= 4'd0;
      par_s  <= 1'b0;
      data   <= 4'd0;
      par    <= 1'b0;
      valid  <= 1'b0;
      perr   <= 1'b0;
      ferr   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      sync  <= {sync[0], rxd};
      valid <= 1'b0;
      busy  <= (state != S_IDLE);

      case (state)
        S_IDLE: begin
          if (!rxd_s) begin
            state <= S_START;
            cnt   <= '0;
          end
        end

        S_START: begin
          if (cnt == HALF_TC) begin
            cnt <= '0;
            if (!rxd_s) begin
              state  <= S_DATA;
              bitidx <= 2'd0;
            end else begin
              // glitch shorter than half a bit: drop it, outputs untouched
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_DATA: begin
          if (cnt == FULL_TC) begin
            cnt           <= '0;
            shreg[bitidx] <= rxd_s;
            if (bitidx == 2'd3) state <= S_PARITY;
            else                bitidx <= bitidx + 2'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_PARITY: begin
          if (cnt == FULL_TC) begin
            cnt   <= '0;
            par_s <= rxd_s;
            state <= S_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_STOP: begin
          if (cnt == FULL_TC) begin
            cnt   <= '0;
            data  <= shreg;
            par   <= par_s;
            perr  <= ^{shreg, par_s};
            ferr  <= ~rxd_s;
            valid <= 1'b1;
            // returning to IDLE right here lets a start bit follow a
            // one-bit stop with no dead time
            state <= rxd_s ? S_IDLE : S_BREAK;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_BREAK: begin
          if (rxd_s) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_nibble_receiver.sv
module tb_serial_nibble_receiver;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic [3:0] data;
  logic       par, valid, perr, ferr, busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         c;
    logic [3:0] d;
    logic       p;
    logic       pe;
    logic       fe;
  } rec_t;

  rec_t vq[$];
  int   busy_rise = -1;
  int   busy_fall = -1;
  logic busy_q    = 1'b0;

  serial_nibble_receiver #(.CLKS_PER_BIT(C)) dut (
    .clk   (clk),
    .rst   (rst),
    .rxd   (rxd),
    .data  (data),
    .par   (par),
    .valid (valid),
    .perr  (perr),
    .ferr  (ferr),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // records every valid pulse and busy edge, sampled mid-cycle
  always @(negedge clk) begin
    rec_t r;
    if (valid === 1'b1) begin
      r.c  = cyc;
      r.d  = data;
      r.p  = par;
      r.pe = perr;
      r.fe = ferr;
      vq.push_back(r);
    end
    if (busy === 1'b1 && busy_q !== 1'b1) busy_rise = cyc;
    if (busy !== 1'b1 && busy_q === 1'b1) busy_fall = cyc;
    busy_q = busy;
  end

  // drives one frame, one bit per C cycles; caller is at a negedge
  task automatic send_frame(input logic [3:0] d, input logic p, input logic s,
                            output int c0);
    logic [6:0] bits;
    bits = {s, p, d, 1'b0};
    c0 = cyc;
    for (int i = 0; i < 7; i++) begin
      rxd = bits[i];
      repeat (C) @(negedge clk);
    end
  endtask

  task automatic clear_mon();
    vq.delete();
    busy_rise = -1;
    busy_fall = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (data !== 4'd0) begin bad++; $display("FAIL reset_data got=%b want=0000", data); end
    total++; if (par !== 1'b0)  begin bad++; $display("FAIL reset_par got=%b want=0", par); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
    total++; if (perr !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b want=0", perr); end
    total++; if (ferr !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b want=0", ferr); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_clean();
    int c0;
    clear_mon();
    send_frame(4'b1011, 1'b1, 1'b1, c0);
    repeat (10) @(negedge clk);
    total++; if (vq.size() != 1) begin bad++; $display("FAIL clean_count got=%0d want=1", vq.size()); end
    if (vq.size() >= 1) begin
      total++; if (vq[0].d !== 4'b1011) begin bad++; $display("FAIL clean_data got=%b want=1011", vq[0].d); end
      total++; if (vq[0].p !== 1'b1) begin bad++; $display("FAIL clean_par got=%b want=1", vq[0].p); end
      total++; if (vq[0].pe !== 1'b0) begin bad++; $display("FAIL clean_perr got=%b want=0", vq[0].pe); end
      total++; if (vq[0].fe !== 1'b0) begin bad++; $display("FAIL clean_ferr got=%b want=0", vq[0].fe); end
      total++; if (vq[0].c != c0 + 29) begin bad++; $display("FAIL clean_latency got=%0d want=%0d", vq[0].c, c0 + 29); end
      total++; if (vq[0].c - busy_rise != 25) begin bad++; $display("FAIL clean_busy_to_valid got=%0d want=25", vq[0].c - busy_rise); end
      total++; if (busy_fall != vq[0].c + 1) begin bad++; $display("FAIL clean_busy_fall got=%0d want=%0d", busy_fall, vq[0].c + 1); end
    end
    total++; if (busy_rise != c0 + 4) begin bad++; $display("FAIL clean_busy_rise got=%0d want=%0d", busy_rise, c0 + 4); end
  endtask

  task automatic test_parity_err();
    int c0;
    clear_mon();
    send_frame(4'b1011, 1'b0, 1'b1, c0);
    repeat (10) @(negedge clk);
    total++; if (vq.size() != 1) begin bad++; $display("FAIL perr_count got=%0d want=1", vq.size()); end
    if (vq.size() >= 1) begin
      total++; if (vq[0].d !== 4'b1011) begin bad++; $display("FAIL perr_data got=%b want=1011", vq[0].d); end
      total++; if (vq[0].p !== 1'b0) begin bad++; $display("FAIL perr_par got=%b want=0", vq[0].p); end
      total++; if (vq[0].pe !== 1'b1) begin bad++; $display("FAIL perr_perr got=%b want=1", vq[0].pe); end
      total++; if (vq[0].fe !== 1'b0) begin bad++; $display("FAIL perr_ferr got=%b want=0", vq[0].fe); end
    end
  endtask

  task automatic test_break();
    int c0, cr;
    clear_mon();
    send_frame(4'b0000, 1'b0, 1'b0, c0);
    repeat (20) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL break_busy_held got=%b want=1", busy); end
    total++; if (vq.size() != 1) begin bad++; $display("FAIL break_count got=%0d want=1", vq.size()); end
    if (vq.size() >= 1) begin
      total++; if (vq[0].d !== 4'b0000) begin bad++; $display("FAIL break_data got=%b want=0000", vq[0].d); end
      total++; if (vq[0].fe !== 1'b1) begin bad++; $display("FAIL break_ferr got=%b want=1", vq[0].fe); end
      total++; if (vq[0].pe !== 1'b0) begin bad++; $display("FAIL break_perr got=%b want=0", vq[0].pe); end
    end
    cr = cyc;
    rxd = 1'b1;
    repeat (10) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL break_busy_release got=%b want=0", busy); end
    total++; if (busy_fall != cr + 4) begin bad++; $display("FAIL break_busy_fall got=%0d want=%0d", busy_fall, cr + 4); end
    total++; if (vq.size() != 1) begin bad++; $display("FAIL break_extra_frame got=%0d want=1", vq.size()); end
  endtask

  task automatic test_glitch();
    int c;
    clear_mon();
    c = cyc;
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (15) @(negedge clk);
    total++; if (vq.size() != 0) begin bad++; $display("FAIL glitch_valid got=%0d want=0", vq.size()); end
    total++; if (busy_rise != c + 4) begin bad++; $display("FAIL glitch_busy_rise got=%0d want=%0d", busy_rise, c + 4); end
    total++; if (busy_fall != c + 6) begin bad++; $display("FAIL glitch_busy_fall got=%0d want=%0d", busy_fall, c + 6); end
    total++; if (data !== 4'b0000) begin bad++; $display("FAIL glitch_data_held got=%b want=0000", data); end
    total++; if (ferr !== 1'b1) begin bad++; $display("FAIL glitch_ferr_held got=%b want=1", ferr); end
  endtask

  task automatic test_reset_mid();
    int c0;
    logic [3:0] pre;
    clear_mon();
    pre = 4'b0110;
    rxd = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      rxd = pre[i];
      repeat (C) @(negedge clk);
    end
    rxd = pre[2];
    repeat (C / 2) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before got=%b want=1", busy); end
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    total++; if (ferr !== 1'b0) begin bad++; $display("FAIL rstmid_ferr got=%b want=0", ferr); end
    total++; if ({data, par, valid, perr} !== 7'd0) begin bad++; $display("FAIL rstmid_outputs got=%b want=0000000", {data, par, valid, perr}); end
    @(negedge clk);
    rst = 1'b0;
    rxd = 1'b1;
    repeat (30) @(negedge clk);
    total++; if (vq.size() != 0) begin bad++; $display("FAIL rstmid_aborted_valid got=%0d want=0", vq.size()); end
    clear_mon();
    send_frame(4'b0110, 1'b0, 1'b1, c0);
    repeat (10) @(negedge clk);
    total++; if (vq.size() != 1) begin bad++; $display("FAIL rstmid_count got=%0d want=1", vq.size()); end
    if (vq.size() >= 1) begin
      total++; if (vq[0].d !== 4'b0110) begin bad++; $display("FAIL rstmid_data got=%b want=0110", vq[0].d); end
      total++; if ({vq[0].p, vq[0].pe, vq[0].fe} !== 3'b000) begin bad++; $display("FAIL rstmid_flags got=%b want=000", {vq[0].p, vq[0].pe, vq[0].fe}); end
      total++; if (vq[0].c != c0 + 29) begin bad++; $display("FAIL rstmid_latency got=%0d want=%0d", vq[0].c, c0 + 29); end
    end
  endtask

  task automatic test_back_to_back();
    int c1, c2;
    clear_mon();
    send_frame(4'b0101, 1'b0, 1'b1, c1);
    send_frame(4'b1110, 1'b1, 1'b1, c2);
    repeat (10) @(negedge clk);
    total++; if (vq.size() != 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", vq.size()); end
    if (vq.size() >= 2) begin
      total++; if (vq[0].d !== 4'b0101) begin bad++; $display("FAIL b2b_data0 got=%b want=0101", vq[0].d); end
      total++; if (vq[1].d !== 4'b1110) begin bad++; $display("FAIL b2b_data1 got=%b want=1110", vq[1].d); end
      total++; if ({vq[0].p, vq[0].pe, vq[0].fe} !== 3'b000) begin bad++; $display("FAIL b2b_flags0 got=%b want=000", {vq[0].p, vq[0].pe, vq[0].fe}); end
      total++; if ({vq[1].p, vq[1].pe, vq[1].fe} !== 3'b100) begin bad++; $display("FAIL b2b_flags1 got=%b want=100", {vq[1].p, vq[1].pe, vq[1].fe}); end
      total++; if (vq[1].c - vq[0].c != 7 * C) begin bad++; $display("FAIL b2b_spacing got=%0d want=%0d", vq[1].c - vq[0].c, 7 * C); end
      total++; if (vq[0].c != c1 + 29) begin bad++; $display("FAIL b2b_latency got=%0d want=%0d", vq[0].c, c1 + 29); end
    end
  endtask

  initial begin
    rst = 1'b1;
    rxd = 1'b1;
    test_reset();
    test_clean();
    test_parity_err();
    test_break();
    test_glitch();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_nibble_receiver.md
# serial_nibble_receiver

- Receives 7-bit serial frames on an asynchronous line: start bit (0), 4 data bits LSB first, 1 even-parity bit, stop bit (1).
- Presents the recovered data nibble and parity bit in parallel with a one-cycle valid strobe.
- Sits directly upstream of the even-parity checker stage, which consumes `data[3:0]` and `par`.
- Also flags parity and framing errors itself, so the frame can be qualified without waiting on the checker.

## Interface
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit. Must be even and ≥ 2.
- `clk` input 1: single system clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `rxd` input 1: serial line. Idles high. Asynchronous to `clk`.
- `data` output 4: received nibble. `data[0]` is the first data bit on the line.
- `par` output 1: received parity bit.
- `valid` output 1: one-cycle strobe. `data`, `par`, `perr` and `ferr` are fresh in that cycle.
- `perr` output 1: parity error, `^{data,par} == 1` (odd number of ones).
- `ferr` output 1: framing error, stop bit sampled as 0.
- `busy` output 1: high in every state except IDLE.

## Operation
- `rxd` passes through a 2-flop synchronizer, giving `rxd_s`. All decisions use `rxd_s`.
- Reset values: `data=0`, `par=0`, `valid=0`, `perr=0`, `ferr=0`, `busy=0`. State = IDLE, bit counter = 0, cycle counter = 0, synchronizer flops = 1.
- Reset asserted mid-frame aborts the frame immediately. No `valid` is issued for it.
- States:
  - IDLE: on `rxd_s==0`, go to START and clear the cycle counter.
  - START: wait `CLKS_PER_BIT/2` cycles, then sample.
    - Sample 0: go to DATA, bit index 0.
    - Sample 1: false start (glitch). Return to IDLE; no outputs change.
  - DATA: every `CLKS_PER_BIT` cycles, sample into shift register position `bit index`. After index 3, go to PARITY.
  - PARITY: after `CLKS_PER_BIT` cycles, sample the parity bit and go to STOP.
  - STOP: after `CLKS_PER_BIT` cycles, sample the stop bit. On this edge, register `data`, `par`, `perr`, `ferr` and set `valid=1`.
    - Stop bit 1: go to IDLE.
    - Stop bit 0: go to BREAK.
  - BREAK: wait for `rxd_s==1`, then go to IDLE. No start detection while in BREAK.
- `data`/`par`/`perr`/`ferr` hold their values until the next frame's stop-sample edge.
- `perr` and `ferr` are independent; both may be set together.
- `valid` pulses for every completed frame, including errored ones.
- Cycle counter width is `$clog2(CLKS_PER_BIT)`. It wraps to 0 at each sample point.

## Timing
- Let E0 be the edge where the FSM leaves IDLE. E0 is 2–3 clocks after `rxd` falls, due to the synchronizer.
- Start sample at E0 + `CLKS_PER_BIT/2`.
- Data bit i sampled at E0 + `CLKS_PER_BIT/2` + (i+1)·`CLKS_PER_BIT`.
- Parity sampled at +5·`CLKS_PER_BIT`; stop sampled at +6·`CLKS_PER_BIT`.
- With `CLKS_PER_BIT=4`, stop is sampled at E0+26 and `valid` is high during the cycle E0+26 to E0+27.
- The FSM is back in IDLE one cycle after the stop sample. A start bit arriving immediately after a 1-bit stop is accepted, so back-to-back frames have no dead time.
- A low pulse on `rxd` shorter than `CLKS_PER_BIT/2` cycles is rejected.
- `busy` rises at E0 + 1. It falls the cycle after the stop sample, or after BREAK ends.

## Test plan
- Clean frame, `CLKS_PER_BIT=4`, data bits 1,1,0,1 (LSB first), parity 1, stop 1 → exactly one `valid` pulse with `data=4'b1011`, `par=1`, `perr=0`, `ferr=0`. Pulse occurs 26 clocks after `busy` rise−1.
- Same data with parity 0 → `valid` with `data=4'b1011`, `par=0`, `perr=1`, `ferr=0`.
- Data 0000, parity 0, stop driven 0 then line held low 20 cycles → `valid` with `ferr=1`, `perr=0`. `busy` stays 1 until the line returns high; no second frame is produced.
- 1-cycle low glitch on idle `rxd` → no `valid`. `busy` high for about 2 cycles, then 0. Outputs unchanged.
- `rst` pulse during DATA bit 2 → all outputs 0 immediately, state IDLE. A following clean frame with data 0110, parity 0 is received correctly.
- Two back-to-back frames (0101/p0 then 1110/p1, 1-bit stop each) → two `valid` pulses 7·`CLKS_PER_BIT` = 28 clocks apart, both with correct data and no errors.
